// File: rtl/video_timing_pkg.sv
// Shared 720p timing defaults, pixel levels and encodings for the mask pattern source.
// Imported by the sync counter and by the generator top.
package video_timing_pkg;

    localparam int H_ACTIVE_720P = 1280;
    localparam int H_FP_720P     = 64;
    localparam int H_SYNC_720P   = 128;
    localparam int H_BP_720P     = 192;
    localparam int H_TOTAL_720P  = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;

    localparam int V_ACTIVE_720P = 720;
    localparam int V_FP_720P     = 3;
    localparam int V_SYNC_720P   = 5;
    localparam int V_BP_720P     = 20;
    localparam int V_TOTAL_720P  = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

    localparam logic [23:0] PIXEL_WHITE = 24'hffffff;
    localparam logic [23:0] PIXEL_BLACK = 24'h000000;

    typedef enum logic [1:0] {
        PAT_BLACK   = 2'd0,
        PAT_CHECKER = 2'd1,
        PAT_DOTS    = 2'd2,
        PAT_SINGLE  = 2'd3
    } pattern_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } gen_state_e;

endpackage

// File: rtl/video_sync_counter.sv
// Horizontal/vertical position counters with registered de/h_sync/v_sync decode.
// Counters sit at (0,0) whenever run is low.
module video_sync_counter
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_720P,
    parameter int   H_FP     = H_FP_720P,
    parameter int   H_SYNC   = H_SYNC_720P,
    parameter int   H_BP     = H_BP_720P,
    parameter int   V_ACTIVE = V_ACTIVE_720P,
    parameter int   V_FP     = V_FP_720P,
    parameter int   V_SYNC   = V_SYNC_720P,
    parameter int   V_BP     = V_BP_720P,
    parameter logic SYNC_POL = 1'b1,
    parameter int   HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int   VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [HW-1:0] h_cnt,
    output logic [VW-1:0] v_cnt,
    output logic          active,
    output logic          frame_end,
    output logic          de,
    output logic          h_sync,
    output logic          v_sync
);

    localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    logic h_last;
    logic v_last;
    logic h_in_sync;
    logic v_in_sync;

    always_comb begin
        h_last    = (h_cnt == H_LAST);
        v_last    = (v_cnt == V_LAST);
        frame_end = h_last && v_last;
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        h_in_sync = (h_cnt >= HS_START) && (h_cnt < HS_END);
        v_in_sync = (v_cnt >= VS_START) && (v_cnt < VS_END);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!run) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Decode registers: each output describes the counter value of the previous clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            de     <= 1'b0;
            h_sync <= ~SYNC_POL;
            v_sync <= ~SYNC_POL;
        end else begin
            de     <= run && active;
            h_sync <= (run && h_in_sync) ? SYNC_POL : ~SYNC_POL;
            v_sync <= (run && v_in_sync) ? SYNC_POL : ~SYNC_POL;
        end
    end

endmodule

// File: rtl/mask_pattern_generator.sv
// Binary mask video source: run/idle control, per-frame pattern latch, pixel mux and
// frame counter on top of the shared sync counter.
module mask_pattern_generator
    import video_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = H_ACTIVE_720P,
    parameter int   H_FP      = H_FP_720P,
    parameter int   H_SYNC    = H_SYNC_720P,
    parameter int   H_BP      = H_BP_720P,
    parameter int   V_ACTIVE  = V_ACTIVE_720P,
    parameter int   V_FP      = V_FP_720P,
    parameter int   V_SYNC    = V_SYNC_720P,
    parameter int   V_BP      = V_BP_720P,
    parameter logic SYNC_POL  = 1'b1,
    parameter int   CELL_LOG2 = 4,
    parameter int   DOT_X     = 640,
    parameter int   DOT_Y     = 360
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        de_out,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic [23:0] pixel_out,
    output logic        frame_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    gen_state_e    state;
    gen_state_e    state_nxt;
    logic          run;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          active;
    logic          frame_end;
    logic          frame_first;
    pattern_e      pat_q;
    pattern_e      pat_cur;
    logic          mask;

    assign run = (state == ST_RUN);

    video_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .SYNC_POL (SYNC_POL),
        .HW       (HW),
        .VW       (VW)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .h_cnt     (h_cnt),
        .v_cnt     (v_cnt),
        .active    (active),
        .frame_end (frame_end),
        .de        (de_out),
        .h_sync    (h_sync_out),
        .v_sync    (v_sync_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Leaving RUN is only possible on the last clock of a frame, so frames never truncate.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (enable)               state_nxt = ST_RUN;
            ST_RUN:  if (frame_end && !enable) state_nxt = ST_IDLE;
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    // The (0,0) pixel already uses the newly selected pattern.
    always_comb begin
        frame_first = run && (h_cnt == '0) && (v_cnt == '0);
        pat_cur     = frame_first ? pattern_e'(pattern_sel) : pat_q;
        mask        = 1'b0;
        case (pat_cur)
            PAT_CHECKER: mask = h_cnt[CELL_LOG2] ^ v_cnt[CELL_LOG2];
            PAT_DOTS:    mask = (h_cnt[CELL_LOG2-1:0] == '0) && (v_cnt[CELL_LOG2-1:0] == '0);
            PAT_SINGLE:  mask = (h_cnt == HW'(DOT_X)) && (v_cnt == VW'(DOT_Y));
            default:     mask = 1'b0;
        endcase
        mask = mask && active && run;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q       <= PAT_BLACK;
            pixel_out   <= PIXEL_BLACK;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            if (frame_first) pat_q <= pattern_e'(pattern_sel);
            pixel_out   <= mask ? PIXEL_WHITE : PIXEL_BLACK;
            frame_start <= frame_first;
            if (run && frame_end) frame_count <= frame_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_mask_pattern_generator.sv
// Scoreboard bench for mask_pattern_generator on a reduced 16x10 raster: a frame-level
// reference model queues expected outputs, a monitor compares them every clock.
module tb_mask_pattern_generator;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int CELL = 1;
    localparam int DX = 3, DY = 2;
    localparam int FRAME = HT * VT;

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [23:0] pix;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic        de_out;
    logic        h_sync_out;
    logic        v_sync_out;
    logic [23:0] pixel_out;
    logic        frame_start;
    logic [15:0] frame_count;

    obs_t exp_q[$];
    bit   mon_on = 1'b0;
    int   tests  = 0;
    int   fails  = 0;
    int   cycle  = 0;
    int   m_fc   = 0;

    mask_pattern_generator #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (1'b1), .CELL_LOG2 (CELL), .DOT_X (DX), .DOT_Y (DY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .de_out      (de_out),
        .h_sync_out  (h_sync_out),
        .v_sync_out  (v_sync_out),
        .pixel_out   (pixel_out),
        .frame_start (frame_start),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(logic de, logic hs, logic vs, logic w, logic fs, int fc);
        obs_t o;
        o.de  = de;
        o.hs  = hs;
        o.vs  = vs;
        o.pix = w ? 24'hffffff : 24'h000000;
        o.fs  = fs;
        o.fc  = 16'(fc);
        return o;
    endfunction

    // Expected output describing raster position (x,y) of a frame drawn with pattern pat.
    function automatic obs_t frame_item(int x, int y, int pat, int fc);
        bit act, w;
        act = (x < HA) && (y < VA);
        case (pat)
            1:       w = (((x >> CELL) ^ (y >> CELL)) & 1) == 1;
            2:       w = (x % (1 << CELL) == 0) && (y % (1 << CELL) == 0);
            3:       w = (x == DX) && (y == DY);
            default: w = 1'b0;
        endcase
        return mk(act, (x >= HA + HF) && (x < HA + HF + HS),
                  (y >= VA + VF) && (y < VA + VF + VS),
                  act && w, (x == 0) && (y == 0), fc);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // One idle clock: DUT is (or stays) idle, inputs are don't-care apart from enable.
    task automatic idle_cycle(input bit en);
        @(negedge clk);
        enable      = en;
        pattern_sel = 2'($urandom_range(0, 3));
        exp_q.push_back(mk(0, 0, 0, 0, 0, m_fc));
    endtask

    // One full frame; pattern_sel switches to pat1 at chg_idx, enable drops at drop_idx.
    task automatic play_frame(input int pat0, input int pat1, input int chg_idx, input int drop_idx);
        for (int y = 0; y < VT; y++) begin
            for (int x = 0; x < HT; x++) begin
                int idx;
                idx = y * HT + x;
                @(negedge clk);
                pattern_sel = 2'((idx >= chg_idx) ? pat1 : pat0);
                enable      = (idx < drop_idx);
                exp_q.push_back(frame_item(x, y, pat0, m_fc + ((idx == FRAME - 1) ? 1 : 0)));
            end
        end
        m_fc++;
    endtask

    // Monitor: compares the DUT outputs against the queued expectation 1ns after each edge.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (mon_on && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {de_out, h_sync_out, v_sync_out, pixel_out, frame_start, frame_count};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL stream cycle %0d: got de=%0b hs=%0b vs=%0b pix=%h fs=%0b fc=%0d, required de=%0b hs=%0b vs=%0b pix=%h fs=%0b fc=%0d",
                             cycle, a.de, a.hs, a.vs, a.pix, a.fs, a.fc,
                             e.de, e.hs, e.vs, e.pix, e.fs, e.fc);
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int nf, gap, bound;
        rst         = 1'b1;
        enable      = 1'b1;
        pattern_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_de", 32'(de_out), 0);
        check("reset_hsync", 32'(h_sync_out), 0);
        check("reset_vsync", 32'(v_sync_out), 0);
        check("reset_pixel", 32'(pixel_out), 0);
        check("reset_fs", 32'(frame_start), 0);
        check("reset_fc", 32'(frame_count), 0);

        // Release reset with enable already high: first edge moves to RUN.
        rst = 1'b0;
        exp_q.push_back(mk(0, 0, 0, 0, 0, m_fc));
        mon_on = 1'b1;
        play_frame(0, 0, FRAME, FRAME);
        play_frame(0, 0, FRAME, 3 * HT + 4);
        repeat (20) idle_cycle(1'b0);
        check("fc_after_drop", 32'(frame_count), 2);

        idle_cycle(1'b1);
        play_frame(1, 1, FRAME, FRAME);
        play_frame(3, 0, 5, FRAME);
        play_frame(1, 2, 70, FRAME);
        play_frame(2, 3, 20, FRAME - 1);
        repeat (5) idle_cycle(1'b0);

        for (int it = 0; it < 6; it++) begin
            idle_cycle(1'b1);
            nf = $urandom_range(1, 2);
            for (int f = 0; f < nf; f++) begin
                play_frame($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, FRAME - 1),
                           (f == nf - 1) ? $urandom_range(0, FRAME - 1) : FRAME);
            end
            gap = $urandom_range(1, 10);
            repeat (gap) idle_cycle(1'b0);
        end

        @(posedge clk);
        #2;
        mon_on = 1'b0;
        exp_q.delete();

        // Asynchronous reset in the middle of an active line.
        @(negedge clk);
        enable = 1'b1;
        bound  = 0;
        while (de_out !== 1'b1 && bound < 40) begin
            @(posedge clk);
            #1;
            bound++;
        end
        check("de_before_rst", 32'(de_out), 1);
        check("fc_before_rst", 32'(frame_count), 32'(m_fc));
        #2;
        rst = 1'b1;
        #1;
        check("async_de", 32'(de_out), 0);
        check("async_hsync", 32'(h_sync_out), 0);
        check("async_vsync", 32'(v_sync_out), 0);
        check("async_pixel", 32'(pixel_out), 0);
        check("async_fc", 32'(frame_count), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
